// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: core status codes, FSM
// encoding and the RAM index-width helper.
package dm_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STALL = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_DONE = 2'd2
  } fsm_t;

  // Bits needed to index n entries; never less than 1.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Data RAM: one synchronous write port and NUM_PORTS registered read ports.
// Reads return the pre-write contents when addressing the word being written.
module dm_ram #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned IDX_W     = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          we,
  input  logic [IDX_W-1:0]              waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [NUM_PORTS*IDX_W-1:0]    raddr,
  output logic [NUM_PORTS*DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++)
        rdata[p*DATA_W +: DATA_W] <= mem[raddr[p*IDX_W +: IDX_W]];
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shared data-memory responder: run FSM, round-robin write arbitration with
// one pending slot per core, per-core status, and host preload/unload port.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_ar,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  input  logic [NUM_CORES-1:0]          core_dm_en,
  input  logic [NUM_CORES-1:0]          core_end,
  output logic [NUM_CORES*2-1:0]        core_status,
  output logic [NUM_CORES*DATA_W-1:0]   core_dm_out,
  input  logic                          host_we,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_wdata,
  output logic [DATA_W-1:0]             host_rdata,
  output logic                          done
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam int unsigned PTR_W = idx_width(NUM_CORES);

  fsm_t                   state;
  logic [NUM_CORES-1:0]   pend_v, end_latch, live, req;
  logic [IDX_W-1:0]       pend_addr [NUM_CORES];
  logic [DATA_W-1:0]      pend_data [NUM_CORES];
  logic [IDX_W-1:0]       core_idx  [NUM_CORES];
  logic [DATA_W-1:0]      core_wd   [NUM_CORES];
  logic [PTR_W-1:0]       rr_ptr, gnt_idx, rr_next;
  logic                   gnt_v;
  logic                   ram_we;
  logic [IDX_W-1:0]       ram_waddr;
  logic [DATA_W-1:0]      ram_wdata;
  logic [(NUM_CORES+1)*IDX_W-1:0]  rd_addr;
  logic [(NUM_CORES+1)*DATA_W-1:0] rd_data;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^{host_addr, core_ar};
  assign done = (state == FSM_DONE);

  always_comb begin
    logic [1:0] st;
    st          = ST_IDLE;
    core_status = '0;
    live        = '0;
    req         = '0;
    rd_addr     = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      core_idx[i] = core_ar[i*ADDR_W +: IDX_W];
      core_wd[i]  = core_wdata[i*DATA_W +: DATA_W];
      rd_addr[i*IDX_W +: IDX_W] = core_ar[i*ADDR_W +: IDX_W];
      if (state == FSM_IDLE)                          st = ST_IDLE;
      else if (state == FSM_DONE || end_latch[i])    st = ST_DONE;
      else if (pend_v[i])                             st = ST_STALL;
      else                                            st = ST_RUN;
      core_status[i*2 +: 2] = st;
      live[i] = (state == FSM_RUN) && (st == ST_RUN) && core_dm_en[i];
      req[i]  = (state == FSM_RUN) && (live[i] || pend_v[i]);
    end
    rd_addr[NUM_CORES*IDX_W +: IDX_W] = host_addr[IDX_W-1:0];
  end

  always_comb begin
    int unsigned c;
    c       = 0;
    gnt_v   = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      c = (32'(rr_ptr) + k) % NUM_CORES;
      if (!gnt_v && req[c]) begin
        gnt_v   = 1'b1;
        gnt_idx = PTR_W'(c);
      end
    end
    rr_next = (gnt_idx == PTR_W'(NUM_CORES-1)) ? '0 : gnt_idx + 1'b1;
  end

  // The write port is held off while reset is asserted so a grant in the
  // reset cycle cannot commit a write that reset is meant to discard.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = host_addr[IDX_W-1:0];
    ram_wdata = host_wdata;
    if (!reset) begin
      if (state != FSM_RUN) begin
        ram_we = host_we;
      end else if (gnt_v) begin
        ram_we = 1'b1;
        if (pend_v[gnt_idx]) begin
          ram_waddr = pend_addr[gnt_idx];
          ram_wdata = pend_data[gnt_idx];
        end else begin
          ram_waddr = core_idx[gnt_idx];
          ram_wdata = core_wd[gnt_idx];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (live[i] && !(gnt_v && gnt_idx == PTR_W'(i))) begin
        pend_addr[i] <= core_idx[i];
        pend_data[i] <= core_wd[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FSM_IDLE;
      pend_v    <= '0;
      end_latch <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        FSM_RUN: begin
          if (&end_latch && !(|pend_v)) state <= FSM_DONE;
          end_latch <= end_latch | core_end;
          if (gnt_v) rr_ptr <= rr_next;
          for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (gnt_v && gnt_idx == PTR_W'(i)) pend_v[i] <= 1'b0;
            else if (live[i])                  pend_v[i] <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state     <= FSM_RUN;
            pend_v    <= '0;
            end_latch <= '0;
            rr_ptr    <= '0;
          end
        end
      endcase
    end
  end

  dm_ram #(
    .NUM_PORTS (NUM_CORES + 1),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign core_dm_out = rd_data[NUM_CORES*DATA_W-1:0];
  assign host_rdata  = rd_data[NUM_CORES*DATA_W +: DATA_W];

endmodule
